// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS core.
// Used by instr_fetch and fetch_skid_buf.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FULL,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          WORD_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory req/ack bus between fetch (master) and memory (slave).
// Request is held until IM_Ack; IM_RData is valid in the ack cycle.
interface instr_fetch_if #(
    parameter int WL = 32
);

    logic          IM_Req;
    logic [WL-1:0] IM_Addr;
    logic          IM_Ack;
    logic [31:0]   IM_RData;

    modport master (
        output IM_Req,
        output IM_Addr,
        input  IM_Ack,
        input  IM_RData
    );

    modport slave (
        input  IM_Req,
        input  IM_Addr,
        output IM_Ack,
        output IM_RData
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pcplus4} holding register for the fetch stage.
// Flush wins over load, load wins over pop.
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int WL = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   instr_in,
    input  logic [WL-1:0] pc4_in,
    output logic [31:0]   instr,
    output logic [WL-1:0] pc4,
    output logic          full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= instr_in;
            pc4   <= pc4_in;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack bus, one-entry skid.
// Define BRANCH_DELAY_SLOT_EN to keep one delay-slot instruction on Redir.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int            WL       = 32,
    parameter logic [WL-1:0] RESET_PC = WL'(DEF_RESET_PC)
) (
    input  logic          CLK,
    input  logic          RST_N,
    instr_fetch_if.master im,
    input  logic          Stall,
    input  logic          Redir,
    input  logic [WL-1:0] RedirPC,
    output logic [31:0]   Instr,
    output logic [15:0]   Imm,
    output logic [WL-1:0] PCPlus4,
    output logic          Valid
);

    fetch_state_t  state;
    logic [WL-1:0] pc;
    logic [WL-1:0] pc_nxt4;
    logic [WL-1:0] tgt;
    logic          consume;
    logic          acc;
    logic          skid_load;
    logic          skid_pop;
    logic          skid_full;
    logic [31:0]   skid_instr;
    logic [WL-1:0] skid_pc4;
`ifdef BRANCH_DELAY_SLOT_EN
    logic          pend_vld;
    logic [WL-1:0] pend_pc;
`endif

    assign pc_nxt4     = pc + WL'(WORD_BYTES);
    assign tgt         = RedirPC & ~(WL'(3));
    assign im.IM_Req   = (state == FETCH) || (state == DRAIN);
    assign im.IM_Addr  = pc;
    assign Imm         = Instr[15:0];
    assign consume     = Valid && !Stall;
    assign acc         = im.IM_Req && im.IM_Ack;

    assign skid_load = !Redir && (state == FETCH) && acc
                       && Valid && Stall;
    assign skid_pop  = !Redir && (state == FULL) && skid_full
                       && consume;

    fetch_skid_buf #(
        .WL (WL)
    ) u_skid (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (skid_load),
        .pop      (skid_pop),
        .flush    (Redir),
        .instr_in (im.IM_RData),
        .pc4_in   (pc_nxt4),
        .instr    (skid_instr),
        .pc4      (skid_pc4),
        .full     (skid_full)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            Valid   <= 1'b0;
            Instr   <= NOP_INSTR;
            PCPlus4 <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_vld <= 1'b0;
            pend_pc  <= '0;
`endif
        end else if (Redir) begin
`ifdef BRANCH_DELAY_SLOT_EN
            // Current output is the slot; otherwise the in-flight word is.
            if (Valid) begin
                Valid    <= Stall;
                pc       <= tgt;
                pend_vld <= 1'b0;
                state    <= (im.IM_Req && !im.IM_Ack) ? DRAIN : FETCH;
            end else if (state == FETCH && acc) begin
                Instr    <= im.IM_RData;
                PCPlus4  <= pc_nxt4;
                Valid    <= 1'b1;
                pc       <= tgt;
                pend_vld <= 1'b0;
            end else if (state == FETCH || state == IDLE) begin
                pend_pc  <= tgt;
                pend_vld <= 1'b1;
                state    <= FETCH;
            end else begin
                pc    <= tgt;
                state <= (im.IM_Req && !im.IM_Ack) ? DRAIN : FETCH;
            end
`else
            Valid <= 1'b0;
            pc    <= tgt;
            state <= (im.IM_Req && !im.IM_Ack) ? DRAIN : FETCH;
`endif
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (acc) begin
                        if (Valid && Stall) begin
                            state <= FULL;
                        end else begin
                            Instr   <= im.IM_RData;
                            PCPlus4 <= pc_nxt4;
                            Valid   <= 1'b1;
                        end
`ifdef BRANCH_DELAY_SLOT_EN
                        pc       <= pend_vld ? pend_pc : pc_nxt4;
                        pend_vld <= 1'b0;
`else
                        pc <= pc_nxt4;
`endif
                    end else if (consume) begin
                        Valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (skid_pop) begin
                        Instr   <= skid_instr;
                        PCPlus4 <= skid_pc4;
                        state   <= FETCH;
                    end
                end
                DRAIN: begin
                    if (consume) Valid <= 1'b0;
                    if (im.IM_Ack) state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
